// File: rtl/watch_set_ctrl.sv
// watch_set_ctrl
//   Set-mode controller for a 32.768 kHz wristwatch. Two debounced buttons
//   (mode, inc) step through RUN -> SET_H -> SET_M -> RUN, issue +1 hour /
//   +1 minute pulses with long-press auto-repeat, time out back to RUN after
//   an idle period, and blink the digits being edited.
//
// Ports
//   clk_crystal_i  in   crystal clock, all state on rising edge
//   rstn_i         in   async active-low reset
//   bt_mode_i      in   mode button level (1 = pressed)
//   bt_inc_i       in   increment button level (1 = pressed)
//   mode_o         out  2'b00 RUN, 2'b01 SET_H, 2'b10 SET_M
//   run_en_o       out  seconds-divider enable (RUN only)
//   plus_1h_o      out  one-cycle +1 hour pulse
//   plus_1m_o      out  one-cycle +1 minute pulse
//   clr_sec_o      out  one-cycle seconds-divider clear (leaving SET_M by button)
//   blank_h_o      out  blank hour digits
//   blank_m_o      out  blank minute digits
module watch_set_ctrl #(
  parameter int unsigned LONG_PRESS = 32768,
  parameter int unsigned REPEAT     = 8192,
  parameter int unsigned TIMEOUT    = 983040,
  parameter int unsigned BLINK_HALF = 16384
) (
  input  logic       clk_crystal_i,
  input  logic       rstn_i,
  input  logic       bt_mode_i,
  input  logic       bt_inc_i,
  output logic [1:0] mode_o,
  output logic       run_en_o,
  output logic       plus_1h_o,
  output logic       plus_1m_o,
  output logic       clr_sec_o,
  output logic       blank_h_o,
  output logic       blank_m_o
);

  localparam int CW = 20;
  localparam logic [CW-1:0] LP_C = CW'(LONG_PRESS);
  localparam logic [CW-1:0] RP_C = CW'(REPEAT);
  localparam logic [CW-1:0] TO_C = CW'(TIMEOUT);
  localparam logic [CW-1:0] BH_C = CW'(BLINK_HALF);

  typedef enum logic [1:0] {
    S_RUN   = 2'b00,
    S_SET_H = 2'b01,
    S_SET_M = 2'b10
  } state_t;

  state_t        r_state;
  logic          r_started;   // low for the first cycle after reset
  logic          r_mode_prev;
  logic          r_inc_prev;
  logic [CW-1:0] r_hold;      // cycles inc held since its edge, stops at LONG_PRESS
  logic [CW-1:0] r_rep;       // 0 = not repeating, else 1..REPEAT
  logic [CW-1:0] r_idle;
  logic [CW-1:0] r_blink;
  logic          r_phase;
  logic          r_run_en;
  logic          r_plus_1h;
  logic          r_plus_1m;
  logic          r_clr_sec;
  logic          r_blank_h;
  logic          r_blank_m;

  logic   w_mode_edge;
  logic   w_inc_edge;
  logic   w_in_set;
  logic   w_timeout;
  logic   w_fire_rpt;
  logic   w_fire;
  logic   w_state_chg;
  state_t w_next;

  // The first cycle after reset only samples the button levels, so a button
  // held through reset release never looks like a fresh press.
  assign w_mode_edge = r_started & bt_mode_i & ~r_mode_prev;
  assign w_inc_edge  = r_started & bt_inc_i  & ~r_inc_prev;
  assign w_in_set    = (r_state != S_RUN);
  assign w_timeout   = w_in_set & (r_idle == TO_C);

  // Repeat fires once when the hold count first reaches LONG_PRESS (r_rep
  // still 0), then each time r_rep cycles round to REPEAT.
  assign w_fire_rpt  = w_in_set & bt_inc_i & ~w_mode_edge &
                       (((r_hold == LP_C) && (r_rep == '0)) || (r_rep == RP_C));
  // A mode edge always wins over any increment in the same cycle.
  assign w_fire      = w_in_set & ~w_mode_edge & (w_inc_edge | w_fire_rpt);

  always_comb begin
    w_next = r_state;
    if (w_mode_edge) begin
      case (r_state)
        S_RUN:   w_next = S_SET_H;
        S_SET_H: w_next = S_SET_M;
        default: w_next = S_RUN;
      endcase
    end else if (w_timeout) begin
      w_next = S_RUN;
    end
  end

  assign w_state_chg = (w_next != r_state);

  always_ff @(posedge clk_crystal_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= S_RUN;
      r_started   <= 1'b0;
      r_mode_prev <= 1'b0;
      r_inc_prev  <= 1'b0;
      r_hold      <= '0;
      r_rep       <= '0;
      r_idle      <= '0;
      r_blink     <= '0;
      r_phase     <= 1'b0;
      r_run_en    <= 1'b1;
      r_plus_1h   <= 1'b0;
      r_plus_1m   <= 1'b0;
      r_clr_sec   <= 1'b0;
      r_blank_h   <= 1'b0;
      r_blank_m   <= 1'b0;
    end else begin
      r_started   <= 1'b1;
      r_mode_prev <= bt_mode_i;
      r_inc_prev  <= bt_inc_i;

      r_state     <= w_next;
      r_run_en    <= (w_next == S_RUN);
      // Only a button-driven exit from SET_M restarts the seconds; a timeout
      // exit does not.
      r_clr_sec   <= w_mode_edge & (r_state == S_SET_M);
      r_plus_1h   <= w_fire & (r_state == S_SET_H);
      r_plus_1m   <= w_fire & (r_state == S_SET_M);
      r_blank_h   <= (r_state == S_SET_H) & r_phase & ~bt_inc_i;
      r_blank_m   <= (r_state == S_SET_M) & r_phase & ~bt_inc_i;

      // Hold / repeat. Counting only starts from an inc edge (r_hold=1), so a
      // button still held across a state change stays inert until re-pressed.
      if (w_state_chg || !w_in_set || !bt_inc_i) begin
        r_hold <= '0;
        r_rep  <= '0;
      end else if (w_inc_edge) begin
        r_hold <= {{(CW-1){1'b0}}, 1'b1};
        r_rep  <= '0;
      end else if (r_hold != '0) begin
        if (r_hold < LP_C) r_hold <= r_hold + 1'b1;
        if (w_fire_rpt)
          r_rep <= {{(CW-1){1'b0}}, 1'b1};
        else if ((r_rep != '0) && (r_rep < RP_C))
          r_rep <= r_rep + 1'b1;
      end

      // Idle counter saturates at TIMEOUT; reaching it forces the state back
      // to RUN, which clears it again.
      if (w_state_chg || !w_in_set || w_mode_edge || w_inc_edge || bt_inc_i)
        r_idle <= '0;
      else if (r_idle < TO_C)
        r_idle <= r_idle + 1'b1;

      if (r_blink >= (BH_C - 1'b1)) begin
        r_blink <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_blink <= r_blink + 1'b1;
      end
    end
  end

  assign mode_o    = r_state;
  assign run_en_o  = r_run_en;
  assign plus_1h_o = r_plus_1h;
  assign plus_1m_o = r_plus_1m;
  assign clr_sec_o = r_clr_sec;
  assign blank_h_o = r_blank_h;
  assign blank_m_o = r_blank_m;

endmodule
